// File: rtl/spi_cmd_parser_if.sv
// -----------------------------------------------------------------------------
// spi_cmd_parser_if
// Bundles the signals between the SPI slave byte receiver, the command parser
// and the control logic that consumes decoded commands.
//
//   cs_n       raw SPI chip select, active low, asynchronous to clk
//   rxd_data   received byte from the SPI slave
//   rxd_flag   level flag, high from bit 0 of a byte until the next byte's MSB
//   txd_data   status byte returned to the master on MISO
//   cmd_valid  one-cycle pulse for each good frame
//   cmd_code   command byte of the last good frame
//   cmd_param  {param_hi, param_lo} of the last good frame
//   err_cnt    saturating count of bad frames
//   busy       a frame is partially received
//
// The slave modport is the parser's view; the master modport is the view of
// whatever drives the receive side and observes the results.
// -----------------------------------------------------------------------------
interface spi_cmd_parser_if;
    logic        cs_n;
    logic [7:0]  rxd_data;
    logic        rxd_flag;
    logic [7:0]  txd_data;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic [15:0] cmd_param;
    logic [7:0]  err_cnt;
    logic        busy;

    modport slave (
        input  cs_n, rxd_data, rxd_flag,
        output txd_data, cmd_valid, cmd_code, cmd_param, err_cnt, busy
    );

    modport master (
        output cs_n, rxd_data, rxd_flag,
        input  txd_data, cmd_valid, cmd_code, cmd_param, err_cnt, busy
    );
endinterface

// File: rtl/spi_cmd_parser.sv
// -----------------------------------------------------------------------------
// spi_cmd_parser
// Assembles 5-byte command frames (HEADER, cmd, param_hi, param_lo, checksum)
// from the SPI slave byte receiver, validates the checksum (8-bit sum of cmd,
// param_hi and param_lo) and presents the decoded command. Reports the result
// of each frame through the status byte shifted back on MISO.
//
// Ports:
//   clk    system clock, same domain as the SPI slave
//   rst_n  asynchronous active-low reset
//   bus    spi_cmd_parser_if.slave (receive side, status and command outputs)
//
// A frame is abandoned (NAK_ABORT, error counted) when chip select rises or
// when no byte arrives for TIMEOUT_CYC cycles while a frame is in progress.
// -----------------------------------------------------------------------------
module spi_cmd_parser #(
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter int         TIMEOUT_CYC = 500000,
    parameter logic [7:0] ACK_CODE    = 8'h5A,
    parameter logic [7:0] NAK_CSUM    = 8'hE1,
    parameter logic [7:0] NAK_ABORT   = 8'hE2
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_cmd_parser_if.slave   bus
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {IDLE, CMD, PH, PL, CSUM} state_t;

    state_t             state, state_n;
    logic               flag_d;
    logic               cs_s1, cs_s2, cs_s3;
    logic               byte_stb, cs_rise;
    logic [CNT_W-1:0]   tmo_cnt;
    logic [7:0]         cmd_r, ph_r, pl_r, sum;
    logic               frame_ok, frame_bad, abort;

    logic [7:0]         txd_data;
    logic               cmd_valid;
    logic [7:0]         cmd_code;
    logic [15:0]        cmd_param;
    logic [7:0]         err_cnt;

    // The receiver's flag is a level; only its rising edge marks a new byte.
    assign byte_stb = bus.rxd_flag & ~flag_d;
    assign cs_rise  = cs_s2 & ~cs_s3;

    // cs_n is asynchronous: two flops for metastability, a third for edge detect.
    // Reset to 1 so that a deselected bus at reset release is not seen as a rise.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of the others, matching real hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_s1  <= 1'b1;
            cs_s2  <= 1'b1;
            cs_s3  <= 1'b1;
            flag_d <= 1'b0;
        end else begin
            cs_s1  <= bus.cs_n;
            cs_s2  <= cs_s1;
            cs_s3  <= cs_s2;
            flag_d <= bus.rxd_flag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Priority: cs_rise abort > byte_stb > timeout. A byte coinciding with a
    // cs rise is dropped, even in IDLE.
    // NOTE: every output of this block is given a default first so that no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_n   = state;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        abort     = 1'b0;
        if (cs_rise) begin
            if (state != IDLE) begin
                state_n = IDLE;
                abort   = 1'b1;
            end
        end else if (byte_stb) begin
            unique case (state)
                IDLE: if (bus.rxd_data == HEADER) state_n = CMD;
                CMD:  state_n = PH;
                PH:   state_n = PL;
                PL:   state_n = CSUM;
                CSUM: begin
                    state_n   = IDLE;
                    frame_ok  = (bus.rxd_data == sum);
                    frame_bad = (bus.rxd_data != sum);
                end
                default: state_n = IDLE;
            endcase
        end else if (state != IDLE && tmo_cnt == TMO_LAST) begin
            state_n = IDLE;
            abort   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt   <= '0;
            cmd_r     <= 8'h00;
            ph_r      <= 8'h00;
            pl_r      <= 8'h00;
            sum       <= 8'h00;
            txd_data  <= 8'h00;
            cmd_valid <= 1'b0;
            cmd_code  <= 8'h00;
            cmd_param <= 16'h0000;
            err_cnt   <= 8'h00;
        end else begin
            // Counter is zero whenever the FSM sits in IDLE and restarts per byte.
            if (byte_stb || state_n == IDLE) tmo_cnt <= '0;
            else                             tmo_cnt <= tmo_cnt + 1'b1;

            if (byte_stb && !cs_rise) begin
                unique case (state)
                    CMD: begin
                        cmd_r <= bus.rxd_data;
                        sum   <= bus.rxd_data;
                    end
                    PH: begin
                        ph_r <= bus.rxd_data;
                        sum  <= sum + bus.rxd_data;
                    end
                    PL: begin
                        pl_r <= bus.rxd_data;
                        sum  <= sum + bus.rxd_data;
                    end
                    default: ;
                endcase
            end

            cmd_valid <= frame_ok;
            if (frame_ok) begin
                cmd_code  <= cmd_r;
                cmd_param <= {ph_r, pl_r};
                txd_data  <= ACK_CODE;
            end else if (frame_bad) begin
                txd_data  <= NAK_CSUM;
            end else if (abort) begin
                txd_data  <= NAK_ABORT;
            end

            if ((frame_bad || abort) && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end

    assign bus.txd_data  = txd_data;
    assign bus.cmd_valid = cmd_valid;
    assign bus.cmd_code  = cmd_code;
    assign bus.cmd_param = cmd_param;
    assign bus.err_cnt   = err_cnt;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_spi_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_spi_cmd_parser
// Directed bench for spi_cmd_parser with a short inter-byte timeout.
// Bytes are delivered as the receiver does: the level flag drops, then rises
// with the new byte. Outputs are sampled 1 time unit after the clock edge.
// -----------------------------------------------------------------------------
module tb_spi_cmd_parser;

    localparam int TMO = 100;

    logic clk = 1'b0;
    logic rst_n;

    spi_cmd_parser_if bus();

    spi_cmd_parser #(.TIMEOUT_CYC(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_err = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns right at the clock edge that consumes the byte strobe.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1 bus.rxd_flag = 1'b0;
        @(posedge clk); #1 bus.rxd_data = b; bus.rxd_flag = 1'b1;
        @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4);
        send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3); send_byte(b4);
    endtask

    task automatic bump_err();
        if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
    endtask

    initial begin
        bus.cs_n     = 1'b0;
        bus.rxd_data = 8'h00;
        bus.rxd_flag = 1'b0;
        rst_n        = 1'b1;
        #2 rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_txd",   bus.txd_data,  8'h00);
        check("rst_valid", bus.cmd_valid, 1'b0);
        check("rst_code",  bus.cmd_code,  8'h00);
        check("rst_param", bus.cmd_param, 16'h0000);
        check("rst_err",   bus.err_cnt,   8'h00);
        check("rst_busy",  bus.busy,      1'b0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Good frame
        send_byte(8'hA5); #1 check("good_busy", bus.busy, 1'b1);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h64); send_byte(8'h65);
        #1;
        check("good_valid", bus.cmd_valid, 1'b1);
        check("good_code",  bus.cmd_code,  8'h01);
        check("good_param", bus.cmd_param, 16'h0064);
        check("good_txd",   bus.txd_data,  8'h5A);
        check("good_err",   bus.err_cnt,   8'h00);
        check("good_idle",  bus.busy,      1'b0);
        @(posedge clk); #1 check("good_pulse_end", bus.cmd_valid, 1'b0);

        // Bad checksum; status must hold ACK while this frame is in flight
        send_byte(8'hA5); send_byte(8'h01);
        #1 check("midframe_txd", bus.txd_data, 8'h5A);
        send_byte(8'h00); send_byte(8'h64); send_byte(8'h66);
        bump_err();
        #1;
        check("bad_valid", bus.cmd_valid, 1'b0);
        check("bad_err",   bus.err_cnt,   exp_err);
        check("bad_txd",   bus.txd_data,  8'hE1);
        check("bad_code",  bus.cmd_code,  8'h01);

        // Bad frame with different content: outputs must not pick it up
        send_frame(8'hA5, 8'h09, 8'hAA, 8'hBB, 8'h00);
        bump_err();
        #1;
        check("bad2_code",  bus.cmd_code,  8'h01);
        check("bad2_param", bus.cmd_param, 16'h0064);
        check("bad2_err",   bus.err_cnt,   exp_err);

        // Leading garbage is dropped without an error
        send_byte(8'h33); send_byte(8'hFF);
        #1;
        check("garbage_busy", bus.busy,    1'b0);
        check("garbage_err",  bus.err_cnt, exp_err);
        send_frame(8'hA5, 8'h02, 8'h12, 8'h34, 8'h48);
        #1;
        check("resync_valid", bus.cmd_valid, 1'b1);
        check("resync_code",  bus.cmd_code,  8'h02);
        check("resync_param", bus.cmd_param, 16'h1234);

        // Header value as payload
        send_frame(8'hA5, 8'h10, 8'hA5, 8'h00, 8'hB5);
        #1;
        check("hdr_data_valid", bus.cmd_valid, 1'b1);
        check("hdr_data_code",  bus.cmd_code,  8'h10);
        check("hdr_data_param", bus.cmd_param, 16'hA500);

        // cs_n abort: busy drops on the third edge after the raise
        send_byte(8'hA5); send_byte(8'h01);
        @(posedge clk); #1 bus.cs_n = 1'b1;
        repeat (2) @(posedge clk); #1 check("cs_busy_2clk", bus.busy, 1'b1);
        @(posedge clk); #1;
        bump_err();
        check("cs_busy_3clk", bus.busy,     1'b0);
        check("cs_err",       bus.err_cnt,  exp_err);
        check("cs_txd",       bus.txd_data, 8'hE2);
        bus.cs_n = 1'b0;
        repeat (4) @(posedge clk);
        send_frame(8'hA5, 8'h04, 8'h00, 8'h01, 8'h05);
        #1;
        check("post_cs_valid", bus.cmd_valid, 1'b1);
        check("post_cs_code",  bus.cmd_code,  8'h04);
        check("post_cs_param", bus.cmd_param, 16'h0001);

        // Byte strobe in the same cycle as cs_rise: one error, byte dropped
        send_byte(8'hA5); send_byte(8'h06);
        @(posedge clk); #1 bus.cs_n = 1'b1; bus.rxd_flag = 1'b0;
        repeat (2) @(posedge clk); #1 bus.rxd_data = 8'h77; bus.rxd_flag = 1'b1;
        @(posedge clk); #1;
        bump_err();
        check("cs_stb_busy", bus.busy,     1'b0);
        check("cs_stb_err",  bus.err_cnt,  exp_err);
        check("cs_stb_txd",  bus.txd_data, 8'hE2);
        @(posedge clk); #1 check("cs_stb_err_once", bus.err_cnt, exp_err);
        bus.cs_n = 1'b0;
        repeat (4) @(posedge clk);

        // Timeout: abort on the TMO-th edge after the last byte
        send_byte(8'hA5); send_byte(8'h03);
        repeat (TMO - 1) @(posedge clk); #1 check("tmo_busy_before", bus.busy, 1'b1);
        @(posedge clk); #1;
        bump_err();
        check("tmo_busy",  bus.busy,     1'b0);
        check("tmo_txd",   bus.txd_data, 8'hE2);
        check("tmo_err",   bus.err_cnt,  exp_err);

        // Byte whose strobe lands on the expiry cycle wins over the timeout
        send_byte(8'hA5); send_byte(8'h03);
        #1 bus.rxd_flag = 1'b0;
        repeat (TMO - 1) @(posedge clk); #1 bus.rxd_data = 8'h00; bus.rxd_flag = 1'b1;
        @(posedge clk); #1;
        check("edge_busy", bus.busy,    1'b1);
        check("edge_err",  bus.err_cnt, exp_err);
        send_byte(8'h10); send_byte(8'h13);
        #1;
        check("edge_valid", bus.cmd_valid, 1'b1);
        check("edge_code",  bus.cmd_code,  8'h03);
        check("edge_param", bus.cmd_param, 16'h0010);
        check("edge_txd",   bus.txd_data,  8'h5A);

        // Saturation over 300 bad frames
        for (int i = 0; i < 300; i++) begin
            send_frame(8'hA5, 8'h01, 8'h00, 8'h64, 8'h66);
            bump_err();
            if (i == 249) begin
                #1 check("sat_reach", bus.err_cnt, exp_err);
            end
        end
        #1;
        check("sat_err",  bus.err_cnt,  8'hFF);
        check("sat_code", bus.cmd_code, 8'h03);

        // Reset mid-frame
        send_byte(8'hA5); send_byte(8'h01);
        #1 bus.rxd_flag = 1'b0; rst_n = 1'b0;
        #1;
        check("mid_rst_txd",   bus.txd_data,  8'h00);
        check("mid_rst_code",  bus.cmd_code,  8'h00);
        check("mid_rst_param", bus.cmd_param, 16'h0000);
        check("mid_rst_err",   bus.err_cnt,   8'h00);
        check("mid_rst_busy",  bus.busy,      1'b0);
        repeat (2) @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        send_frame(8'hA5, 8'h05, 8'h01, 8'h02, 8'h08);
        #1;
        check("post_rst_code",  bus.cmd_code,  8'h05);
        check("post_rst_param", bus.cmd_param, 16'h0102);
        check("post_rst_err",   bus.err_cnt,   8'h00);
        check("post_rst_txd",   bus.txd_data,  8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_cmd_parser.md
Name: spi_cmd_parser

Overview:
- Sits directly downstream of the SPI slave byte receiver on the car-control FPGA.
- Turns the receiver's per-byte level flag into a one-cycle byte strobe, then assembles 5-byte command frames: header 0xA5, cmd, param_hi, param_lo, checksum.
- Validates each frame and presents a decoded command to the motion/camera control logic.
- Drives the status byte that the SPI slave shifts back to the master on MISO.

Parameters:
- HEADER, 8'hA5, frame start byte.
- TIMEOUT_CYC, 500000, max clk cycles allowed between bytes inside a frame (10 ms at 50 MHz).
- ACK_CODE, 8'h5A, status after a good frame.
- NAK_CSUM, 8'hE1, status after a checksum failure.
- NAK_ABORT, 8'hE2, status after CS abort or timeout.

Ports:
- clk  in  1  system clock, same domain as the SPI slave.
- rst_n  in  1  asynchronous active-low reset.
- cs_n  in  1  raw SPI chip select, active low, asynchronous to clk.
- rxd_data  in  8  received byte from the SPI slave.
- rxd_flag  in  1  level: high from bit 0 of a byte until the next byte's MSB or cs_n high.
- txd_data  out  8  status byte handed to the SPI slave for MISO.
- cmd_valid  out  1  one-cycle pulse when a good frame completes.
- cmd_code  out  8  command byte of the last good frame.
- cmd_param  out  16  {param_hi, param_lo} of the last good frame.
- err_cnt  out  8  saturating count of bad frames.
- busy  out  1  high while a frame is partially received (state != IDLE).

Behaviour:
- Reset values: txd_data=0x00, cmd_valid=0, cmd_code=0x00, cmd_param=0x0000, err_cnt=0, busy=0, state=IDLE, timeout counter=0.
- Byte strobe: rxd_flag registered once (flag_d); byte_stb = rxd_flag & ~flag_d. Exactly one strobe per received byte. rxd_data is sampled in the byte_stb cycle.
- cs_n passes through a 2-flop synchroniser (reset value 1). cs_rise = sync high and previous sync low.
- FSM states: IDLE, CMD, PH, PL, CSUM.
  - IDLE: on byte_stb with rxd_data==HEADER go to CMD; any other byte is discarded silently (no error).
  - CMD: byte_stb latches cmd, sum=byte, go to PH.
  - PH: latch param_hi, sum+=byte, go to PL.
  - PL: latch param_lo, sum+=byte, go to CSUM.
  - CSUM: on byte_stb, compare the byte with sum (8-bit, mod 256).
    - Match: cmd_code and cmd_param update, cmd_valid pulses, txd_data=ACK_CODE.
    - Mismatch: err_cnt+1, txd_data=NAK_CSUM, cmd outputs hold.
    - Either way, return to IDLE.
- A HEADER value received in CMD/PH/PL/CSUM is treated as data; there is no resync.
- Latency: cmd_valid is high in the cycle after the byte_stb cycle of the checksum byte, for exactly one cycle. cmd_code, cmd_param and txd_data change in the same cycle as cmd_valid.
- Timeout counter: cleared on every byte_stb and held at 0 in IDLE; otherwise increments. On reaching TIMEOUT_CYC-1 in a non-IDLE state: go to IDLE, err_cnt+1, txd_data=NAK_ABORT.
- cs_rise in a non-IDLE state: go to IDLE, err_cnt+1, txd_data=NAK_ABORT. cs_rise in IDLE: no effect.
- Priority within one cycle: reset > cs_rise abort > byte_stb > timeout. A byte_stb coinciding with a timeout expiry is processed and the counter clears. A byte_stb coinciding with cs_rise is discarded, and only one error is counted.
- err_cnt saturates at 0xFF and never wraps.
- txd_data holds its last code until the next frame result; it never changes mid-frame.
- Asynchronous reset mid-frame returns everything to reset values immediately. The partial frame is lost and no error is counted.

Test Plan:
- Good frame A5 01 00 64 65 -> one cmd_valid pulse one clk after the last byte_stb; cmd_code=0x01, cmd_param=0x0064, txd_data=0x5A, err_cnt=0.
- Bad checksum A5 01 00 64 66 -> no cmd_valid; err_cnt=1; txd_data=0xE1; cmd_code/cmd_param keep their previous values.
- Leading garbage 33 FF then A5 02 12 34 48 -> garbage ignored with err_cnt unchanged; cmd_code=0x02, cmd_param=0x1234; payload byte A5 (frame A5 10 A5 00 B5) accepted as data.
- cs_n raised after A5 01 -> busy falls within 3 clk; err_cnt+1; txd_data=0xE2; the next full frame decodes correctly.
- Timeout with TIMEOUT_CYC=100: send A5 03 then stall 100 clk -> IDLE, txd_data=0xE2, err_cnt+1. A byte arriving exactly on the expiry cycle is accepted instead. Reset asserted mid-frame -> all outputs 0 and busy=0.
- Saturation: 300 bad-checksum frames -> err_cnt stays 0xFF.
